tdc_phase_decoder: RTL and testbench
====================================

Name: tdc_phase_decoder

Overview:
- Digital post-processing stage directly downstream of the TDC analog model. Runs in the reference-clock (`clk`) domain.
- Each enabled cycle it consumes the sampled 16-phase ring-oscillator vector (`phase`) and the 7-bit ripple count (`ripple_count`).
- It decodes them into a 12-bit oscillator phase word (coarse count plus 5-bit fine Johnson index) and computes the wrap-aware per-cycle phase increment.
- It accumulates the increment into an unwrapped phase for the ADPLL loop filter, and flags and counts malformed (bubbled) fine codes.

Parameters:
- COARSE_W, 7, width of `ripple_count`.
- FINE_W, 5, fine index width (32 Johnson states of the 16-phase ring).
- ACC_W, 20, width of the unwrapped phase accumulator.
- ERR_W, 8, width of the saturating code-error counter.

Ports:
- clk  input  1  reference clock; also the TDC sampling clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sample enable; low = pipeline holds, no valid output.
- acc_clr  input  1  synchronous clear of `phase_acc` and `err_cnt`.
- ripple_count  input  COARSE_W  coarse count from the TDC.
- phase  input  16  sampled ring phases from the TDC; odd phases already inverted.
- phase_word  output  COARSE_W+FINE_W  decoded phase, {coarse, fine}.
- dphase  output  COARSE_W+FINE_W  signed phase increment since the previous sample.
- phase_acc  output  ACC_W  signed unwrapped phase sum.
- valid  output  1  `dphase` and `phase_acc` updated this cycle.
- code_err  output  1  current fine code had a bubble.
- err_cnt  output  ERR_W  saturating count of `code_err` events.

Behaviour:
- Reset (`rst_n`=0, asynchronous): all registers and outputs are 0, and the primed flag is cleared.
- Stage 0 (cycle N, `en`=1): register `ripple_count` and `phase`. The stage-0 valid bit follows `en`.
- Stage 1 (N+1): fine decode.
  - p = popcount(phase).
  - If phase[15]=0: fine = p.
  - Else if p=16: fine = 16.
  - Else: fine = 32 - p.
  - `phase_word` = {coarse, fine}, width 12.
  - `code_err` = 1 when the count of bit transitions between adjacent indices 0..15 exceeds 1. The popcount-based fine value is still used.
- Stage 2 (N+2): increment and accumulate.
  - `dphase` = (word - prev_word) mod 2^12, interpreted as two's complement (range -2048..+2047). Then prev_word <= word.
  - `phase_acc` += sign-extended `dphase`; the accumulator wraps modulo 2^ACC_W.
- Latency and outputs:
  - Latency from sample to `valid` is 2 cycles.
  - `valid` is a 1-cycle pulse per processed sample.
  - `phase_word` and `code_err` appear at N+1 and hold until the next sample.
- Priming: the first sample after reset, or after `en` falls and rises again, only loads prev_word.
  - No `valid` for that sample, `dphase` = 0, `phase_acc` unchanged. The primed flag is then set.
  - `en`=0 clears the primed flag.
- `en`=0: no stage advances, in-flight samples are frozen, and `valid`=0. Samples in flight when `en` falls are discarded.
- `acc_clr`: next cycle `phase_acc`=0 and `err_cnt`=0.
  - If a valid `dphase` arrives in the same cycle, clear wins: that `dphase` is still output but not accumulated. prev_word still updates.
- `err_cnt` increments once per stage-1 sample with `code_err`=1, and saturates at 2^ERR_W-1.
- Coarse and fine are treated as coherent; no coarse/fine realignment is done in this block.

Test Plan:
- Reset check: hold `rst_n`=0 with random inputs, then release → all outputs 0. Assert `rst_n` mid-stream → outputs 0 immediately, without waiting for `clk`.
- Fine decode:
  - phase = 0x0000 / 0x00FF / 0xFFFF / 0xFF00 / 0xFFFE → fine = 0 / 8 / 16 / 24 / 17.
  - With count = 3, phase = 0x00FF → `phase_word` = 104.
- Priming and steady increment: `en`=1; word advances by +37 per cycle from 0 →
  - First `valid` appears 3 cycles after `en`, with `dphase` = 37.
  - `phase_acc` = 37·k after k valids.
- Wrap-around:
  - word 4094 (count 127, fine 30) then word 2 (count 0, fine 2) → `dphase` = +4.
  - Reverse order → `dphase` = -4 (0xFFC).
- Bubble: phase = 0x00F7 → `code_err`=1, fine = 7, `err_cnt` increments. Force 300 bubbles → `err_cnt` saturates at 255.
- Control:
  - `acc_clr` asserted in the same cycle as `valid` with `dphase` = 5 → `phase_acc` = 0 and `err_cnt` = 0 next cycle.
  - Toggle `en` low for 2 cycles → no `valid` during the gap; re-priming occurs with no `dphase` emitted for the first new sample.

Source files
------------

// File: rtl/tdc_phase_decoder.sv
// TDC phase decoder: turns the sampled 16-phase ring vector and the ripple
// count into a {coarse, fine} phase word. It then produces the wrap-aware
// per-sample increment and an unwrapped phase accumulator for the ADPLL.
// Pipeline: stage 0 captures the inputs, stage 1 decodes, stage 2 differences
// and accumulates. Sample-to-valid latency is 2 cycles.
module tdc_phase_decoder #(
    parameter int COARSE_W = 7,
    parameter int FINE_W   = 5,
    parameter int ACC_W    = 20,
    parameter int ERR_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         acc_clr,
    input  logic [COARSE_W-1:0]          ripple_count,
    input  logic [15:0]                  phase,
    output logic [COARSE_W+FINE_W-1:0]   phase_word,
    output logic [COARSE_W+FINE_W-1:0]   dphase,
    output logic [ACC_W-1:0]             phase_acc,
    output logic                         valid,
    output logic                         code_err,
    output logic [ERR_W-1:0]             err_cnt
);

    localparam int W = COARSE_W + FINE_W;

    // Pipeline state
    logic [1:0]          vld_q;         // [0]: stage-0 sample held, [1]: stage-1 word held
    logic [COARSE_W-1:0] s0_cnt_q;
    logic [15:0]         s0_phase_q;
    logic [W-1:0]        word_q;
    logic                code_err_q;
    logic [W-1:0]        prev_q;
    logic                primed_q;
    logic [W-1:0]        dphase_q;
    logic                valid_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ERR_W-1:0]    err_q;

    // Combinational decode / difference results
    logic [4:0]          pop_d;
    logic [3:0]          trans_d;
    logic [FINE_W-1:0]   fine_d;
    logic                bubble_d;
    logic [W-1:0]        dphase_d;
    logic [ACC_W-1:0]    dphase_ext_d;

    // Fine decode of the captured ring vector: popcount gives the Johnson
    // position, and phase[15] tells the filling half from the draining half.
    // A clean Johnson code has at most one transition along 0..15.
    always_comb begin
        pop_d   = '0;
        trans_d = '0;
        for (int i = 0; i < 16; i++) pop_d = pop_d + 5'(s0_phase_q[i]);
        for (int i = 0; i < 15; i++) trans_d = trans_d + 4'(s0_phase_q[i] ^ s0_phase_q[i+1]);
        if (!s0_phase_q[15])
            fine_d = FINE_W'(pop_d);
        else if (pop_d == 5'd16)
            fine_d = FINE_W'(5'd16);
        else
            fine_d = FINE_W'(6'd32 - {1'b0, pop_d});
        bubble_d = (trans_d > 4'd1);
    end

    // Modular difference; the top bit of the word-width result is the sign
    always_comb begin
        dphase_d     = word_q - prev_q;
        dphase_ext_d = {{(ACC_W-W){dphase_d[W-1]}}, dphase_d};
    end

    // Pipeline stages; en low freezes data, drops in-flight samples and forces re-priming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            s0_cnt_q   <= '0;
            s0_phase_q <= '0;
            word_q     <= '0;
            code_err_q <= 1'b0;
            prev_q     <= '0;
            primed_q   <= 1'b0;
            dphase_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!en) begin
                vld_q    <= '0;
                primed_q <= 1'b0;
            end else begin
                vld_q      <= {vld_q[0], 1'b1};
                s0_cnt_q   <= ripple_count;
                s0_phase_q <= phase;
                if (vld_q[0]) begin
                    word_q     <= {s0_cnt_q, fine_d};
                    code_err_q <= bubble_d;
                end
                if (vld_q[1]) begin
                    prev_q <= word_q;
                    if (primed_q) begin
                        dphase_q <= dphase_d;
                        valid_q  <= 1'b1;
                    end else begin
                        // First sample of a run only seeds the reference word
                        dphase_q <= '0;
                        primed_q <= 1'b1;
                    end
                end
            end
        end
    end

    // Unwrapped phase accumulator; a clear beats a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_q <= '0;
        else if (acc_clr)
            acc_q <= '0;
        else if (en && vld_q[1] && primed_q)
            acc_q <= acc_q + dphase_ext_d;
    end

    // Saturating count of bubbled fine codes, one per decoded sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= '0;
        else if (acc_clr)
            err_q <= '0;
        else if (en && vld_q[0] && bubble_d && (err_q != {ERR_W{1'b1}}))
            err_q <= err_q + 1'b1;
    end

    assign phase_word = word_q;
    assign code_err   = code_err_q;
    assign dphase     = dphase_q;
    assign valid      = valid_q;
    assign phase_acc  = acc_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_tdc_phase_decoder.sv
// Bench for tdc_phase_decoder: directed vectors, valid outputs checked by a
// queue-based scoreboard, static outputs checked directly.
module tb_tdc_phase_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        acc_clr = 1'b0;
    logic [6:0]  ripple_count = '0;
    logic [15:0] phase = '0;
    logic [11:0] phase_word;
    logic [11:0] dphase;
    logic [19:0] phase_acc;
    logic        valid;
    logic        code_err;
    logic [7:0]  err_cnt;

    tdc_phase_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .acc_clr      (acc_clr),
        .ripple_count (ripple_count),
        .phase        (phase),
        .phase_word   (phase_word),
        .dphase       (dphase),
        .phase_acc    (phase_acc),
        .valid        (valid),
        .code_err     (code_err),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] d;
        logic [19:0] acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   sb_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (sb_on && valid === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected_valid: got dphase 0x%0h with no expected entry", dphase);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_dphase", 32'(dphase), 32'(e.d));
                chk("sb_phase_acc", 32'(phase_acc), 32'(e.acc));
            end
        end
    end

    // Johnson ring encoding of a fine index (stimulus only)
    function automatic logic [15:0] enc(input int f);
        logic [16:0] t;
        if (f <= 16) begin
            t = (17'd1 << f) - 17'd1;
            return t[15:0];
        end
        return 16'hFFFF << (f - 16);
    endfunction

    task automatic drive_word(input int w);
        ripple_count = 7'(w >> 5);
        phase        = enc(w & 31);
        en           = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drive_raw(input logic [6:0] c, input logic [15:0] p);
        ripple_count = c;
        phase        = p;
        en           = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [11:0] d, input logic [19:0] acc);
        exp_t e;
        e.d   = d;
        e.acc = acc;
        q.push_back(e);
    endtask

    task automatic gap(input int n);
        en = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("gap_valid_low", 32'(valid), 32'd0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_phase_word"}, 32'(phase_word), 32'd0);
        chk({tag, "_dphase"}, 32'(dphase), 32'd0);
        chk({tag, "_phase_acc"}, 32'(phase_acc), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_code_err"}, 32'(code_err), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    // Hold a vector for two edges so it reaches the decode stage, then check
    task automatic dec(input logic [6:0] c, input logic [15:0] p,
                       input logic [11:0] wexp, input logic eexp);
        drive_raw(c, p);
        drive_raw(c, p);
        chk("dec_phase_word", 32'(phase_word), 32'(wexp));
        chk("dec_code_err", 32'(code_err), 32'(eexp));
    endtask

    initial begin
        // Reset with random inputs toggling
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en           = 1'b1;
            acc_clr      = 1'($urandom_range(0, 1));
            ripple_count = 7'($urandom);
            phase        = 16'($urandom);
            @(posedge clk); #1;
        end
        chk_zero("in_reset");
        en = 1'b0;
        acc_clr = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_zero("after_reset");

        // Fine decode; valid pulses here are not scored
        dec(7'd0, 16'h0000, 12'd0, 1'b0);
        dec(7'd0, 16'h00FF, 12'd8, 1'b0);
        dec(7'd0, 16'hFFFF, 12'd16, 1'b0);
        dec(7'd0, 16'hFF00, 12'd24, 1'b0);
        dec(7'd0, 16'hFFFE, 12'd17, 1'b0);
        dec(7'd3, 16'h00FF, 12'd104, 1'b0);
        chk("err_cnt_clean", 32'(err_cnt), 32'd0);
        dec(7'd0, 16'h00F7, 12'd7, 1'b1);
        chk("err_cnt_one", 32'(err_cnt), 32'd1);
        for (int i = 0; i < 300; i++) drive_raw(7'd0, 16'h00F7);
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);

        // Gap drops priming; clear accumulator and error count
        gap(1);
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        chk("clr_phase_acc", 32'(phase_acc), 32'd0);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);

        // Priming and steady +37 ramp: samples 0..8, en drops after 8,
        // so samples 1..6 complete, sample 0 primes
        sb_on = 1'b1;
        for (int k = 1; k <= 6; k++) push(12'd37, 20'(37 * k));
        drive_word(0);
        drive_word(37);
        drive_word(74);
        drive_word(111);
        chk("first_valid_timing", 32'(valid), 32'd1);
        for (int k = 4; k <= 8; k++) drive_word(37 * k);
        gap(2);
        chk("ramp_phase_acc", 32'(phase_acc), 32'd222);

        // Wrap-around: 4094 primes, 2 gives +4, 4094 gives -4
        push(12'd4, 20'd226);
        push(12'hFFC, 20'd222);
        drive_word(4094);
        drive_word(2);
        drive_word(4094);
        chk("reprime_no_valid", 32'(valid), 32'd0);
        chk("reprime_dphase_zero", 32'(dphase), 32'd0);
        drive_word(4094);
        drive_word(4094);
        gap(2);

        // acc_clr together with a dphase=5 valid: 10 primes, 15 -> 227,
        // 20 arrives with the clear -> output but not summed, 25 -> 5
        push(12'd5, 20'd227);
        push(12'd5, 20'd0);
        push(12'd5, 20'd5);
        drive_word(10);
        drive_word(15);
        drive_word(20);
        drive_word(25);
        chk("clr_case_valid", 32'(valid), 32'd1);
        acc_clr = 1'b1;
        drive_word(30);
        acc_clr = 1'b0;
        chk("clr_case_phase_acc", 32'(phase_acc), 32'd0);
        chk("clr_case_err_cnt", 32'(err_cnt), 32'd0);
        drive_word(35);
        gap(2);

        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_missing_valid: got %0d entries left expected 0", q.size());
        end

        // Asynchronous reset mid-stream
        sb_on = 1'b0;
        drive_raw(7'd5, 16'h00F7);
        drive_raw(7'd9, 16'h00F7);
        drive_raw(7'd9, 16'h0FFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Runaway guard
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
